// File: rtl/rf_writeback_ctrl_if.sv
// Handshake and write-port bundle for the register-file writeback controller.
// master drives the request side (pipeline/testbench); slave is the controller.
interface rf_writeback_ctrl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        resp_err;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
               ld_resp_valid, ld_resp_data, rs1_addr, rs2_addr,
        input  alu_ready, ld_issue_ready, hazard, rf_we, rf_waddr, rf_wdata, resp_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
               ld_resp_valid, ld_resp_data, rs1_addr, rs2_addr,
        output alu_ready, ld_issue_ready, hazard, rf_we, rf_waddr, rf_wdata, resp_err
    );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port arbiter: merges ALU results with in-order load responses,
// tracks outstanding load destinations in a busy scoreboard and flags decode hazards.
module rf_writeback_ctrl #(
    parameter int unsigned LD_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    rf_writeback_ctrl_if.slave bus
);
    localparam int unsigned PtrW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     busy_q, busy_d;
    logic [4:0]      pend_q [LD_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [31:0]     rf_wdata_q;
    logic            resp_err_q;

    logic            issue_acc, resp_acc, alu_acc;
    logic [4:0]      head_rd;

    assign head_rd = pend_q[rd_ptr_q];

    // Readiness uses the pre-pop count and busy bits, so a same-cycle pop never frees a slot.
    assign bus.ld_issue_ready = (count_q < CntW'(LD_DEPTH)) &&
                                ((bus.ld_issue_rd == 5'd0) || !busy_q[bus.ld_issue_rd]);
    assign issue_acc = bus.ld_issue_valid && bus.ld_issue_ready;
    assign resp_acc  = bus.ld_resp_valid && (count_q != '0);

    assign bus.alu_ready = !resp_acc && ((bus.alu_rd == 5'd0) || !busy_q[bus.alu_rd]);
    assign alu_acc       = bus.alu_valid && bus.alu_ready;

    assign bus.hazard = ((bus.rs1_addr != 5'd0) && busy_q[bus.rs1_addr]) ||
                        ((bus.rs2_addr != 5'd0) && busy_q[bus.rs2_addr]);

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.resp_err = resp_err_q;

    always_comb begin
        busy_d = busy_q;
        if (resp_acc) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_acc && (bus.ld_issue_rd != 5'd0)) begin
            busy_d[bus.ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        count_d = count_q + CntW'(issue_acc) - CntW'(resp_acc);
    end

    always_ff @(posedge clk) begin
        if (issue_acc) begin
            pend_q[wr_ptr_q] <= bus.ld_issue_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            resp_err_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            if (issue_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (resp_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (bus.ld_resp_valid && (count_q == '0)) begin
                resp_err_q <= 1'b1;
            end
            if (resp_acc) begin
                rf_we_q    <= (head_rd != 5'd0);
                rf_waddr_q <= head_rd;
                rf_wdata_q <= bus.ld_resp_data;
            end else if (alu_acc) begin
                rf_we_q    <= (bus.alu_rd != 5'd0);
                rf_waddr_q <= bus.alu_rd;
                rf_wdata_q <= bus.alu_data;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed plus randomized bench for rf_writeback_ctrl against a queue-based reference model.
module tb_rf_writeback_ctrl;
    localparam int LD_DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rf_writeback_ctrl_if w();

    rf_writeback_ctrl #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding loads as an ordered list of destinations.
    int          pend[$];
    bit          m_err;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (pend[i]) if (pend[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_err   = 1'b0;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
    endtask

    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit iv, input logic [4:0] ird,
                       input bit rv, input logic [31:0] rdat,
                       input logic [4:0] r1, input logic [4:0] r2);
        bit e_ir, e_ar, racc;
        int head;
        w.alu_valid      = av;
        w.alu_rd         = ard;
        w.alu_data       = ad;
        w.ld_issue_valid = iv;
        w.ld_issue_rd    = ird;
        w.ld_resp_valid  = rv;
        w.ld_resp_data   = rdat;
        w.rs1_addr       = r1;
        w.rs2_addr       = r2;
        #1;
        e_ir = (pend.size() < LD_DEPTH) && !m_busy(ird);
        racc = rv && (pend.size() > 0);
        e_ar = !racc && !m_busy(ard);
        chk("ld_issue_ready", {31'd0, w.ld_issue_ready}, {31'd0, e_ir});
        chk("alu_ready", {31'd0, w.alu_ready}, {31'd0, e_ar});
        chk("hazard", {31'd0, w.hazard}, {31'd0, m_busy(r1) || m_busy(r2)});
        if (racc) begin
            head    = pend.pop_front();
            m_we    = (head != 0);
            m_waddr = 5'(head);
            m_wdata = rdat;
        end else if (av && e_ar) begin
            m_we    = (ard != 5'd0);
            m_waddr = ard;
            m_wdata = ad;
        end else begin
            m_we = 1'b0;
        end
        if (rv && !racc) m_err = 1'b1;
        if (iv && e_ir) pend.push_back(int'(ird));
        @(posedge clk);
        #1;
        chk("rf_we", {31'd0, w.rf_we}, {31'd0, m_we});
        chk("rf_waddr", {27'd0, w.rf_waddr}, {27'd0, m_waddr});
        chk("rf_wdata", w.rf_wdata, m_wdata);
        chk("resp_err", {31'd0, w.resp_err}, {31'd0, m_err});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    task automatic issue(input logic [4:0] rd);
        cyc(0, 0, 0, 1, rd, 0, 0, rd, 0);
    endtask

    task automatic resp(input logic [31:0] d);
        cyc(0, 0, 0, 0, 0, 1, d, 0, 0);
    endtask

    // Reset asserted in the middle of the low clock phase.
    task automatic mid_reset(input logic [4:0] r1, input logic [4:0] r2);
        w.rs1_addr = r1;
        w.rs2_addr = r2;
        w.ld_issue_rd = r1;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_hazard", {31'd0, w.hazard}, 32'd0);
        chk("rst_rf_we", {31'd0, w.rf_we}, 32'd0);
        chk("rst_resp_err", {31'd0, w.resp_err}, 32'd0);
        chk("rst_issue_ready", {31'd0, w.ld_issue_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        w.alu_valid = 0; w.alu_rd = 0; w.alu_data = 0;
        w.ld_issue_valid = 0; w.ld_issue_rd = 0;
        w.ld_resp_valid = 0; w.ld_resp_data = 0;
        w.rs1_addr = 5'd1; w.rs2_addr = 5'd2;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_rf_we", {31'd0, w.rf_we}, 32'd0);
        chk("reset_waddr", {27'd0, w.rf_waddr}, 32'd0);
        chk("reset_wdata", w.rf_wdata, 32'd0);
        chk("reset_resp_err", {31'd0, w.resp_err}, 32'd0);
        chk("reset_hazard", {31'd0, w.hazard}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU only
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        chk("alu_wdata", w.rf_wdata, 32'hDEADBEEF);
        chk("alu_waddr", {27'd0, w.rf_waddr}, 32'd5);
        idle(1, 0, 0);

        // Load round trip, response three cycles after issue
        issue(7);
        idle(2, 7, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h1234, 7, 0);
        chk("ld_wdata", w.rf_wdata, 32'h1234);
        chk("ld_waddr", {27'd0, w.rf_waddr}, 32'd7);
        idle(1, 7, 0);

        // Response beats ALU; ALU to a load-busy rd waits
        issue(3);
        cyc(1, 9, 32'h9999, 0, 0, 1, 32'h3333, 3, 9);
        cyc(1, 9, 32'h9999, 0, 0, 0, 0, 3, 9);
        issue(4);
        cyc(1, 4, 32'h4444, 0, 0, 0, 0, 4, 0);
        cyc(1, 4, 32'h4444, 0, 0, 0, 0, 4, 0);
        cyc(1, 4, 32'h4444, 0, 0, 1, 32'hAAAA, 4, 0);
        cyc(1, 4, 32'h4444, 0, 0, 0, 0, 4, 0);

        // FIFO full and pointer wrap
        for (int r = 1; r <= 4; r++) issue(5'(r));
        issue(5);
        cyc(0, 0, 0, 1, 5, 1, 32'h1001, 1, 5);
        issue(5);
        for (int i = 0; i < 4; i++) resp(32'h2000 + i);
        for (int r = 10; r <= 13; r++) issue(5'(r));
        for (int i = 0; i < 2; i++) resp(32'h3000 + i);
        issue(14);
        issue(15);
        for (int i = 0; i < 4; i++) resp(32'h4000 + i);

        // x0 handling and busy refusal
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        resp(32'h5555);
        cyc(1, 0, 32'h6666, 0, 0, 0, 0, 0, 0);
        issue(2);
        issue(2);
        resp(32'h7777);

        // Response with nothing pending, then reset mid-operation
        resp(32'hBAD0);
        chk("err_sticky", {31'd0, w.resp_err}, 32'd1);
        idle(1, 0, 0);
        issue(2);
        issue(6);
        mid_reset(2, 6);
        resp(32'hBAD1);
        chk("stale_err", {31'd0, w.resp_err}, 32'd1);
        mid_reset(0, 0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cyc(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                (pend.size() > 0) && ($urandom_range(0, 2) == 0), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
